game_sequencer: RTL and testbench

Top-level game flow controller for the VGA runner. It sequences the game through menu, countdown, play and game-over phases from the start button, collision and scoring events, and a per-frame tick. It drives the `status` select consumed by the pixel layer mux in `Main`, a `play_en` gate for character and block motion, and a saturating speed level that configures block fall rate.

---
 rtl/game_pkg.sv | 14 +
 rtl/game_sequencer_rise_detect.sv | 19 +
 rtl/game_sequencer.sv | 119 +++++++++++
 tb/tb_game_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and widths for the game flow controller.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam int unsigned LEVEL_W = 3;
  localparam int unsigned CNT_W   = 8;

endpackage

// File: rtl/game_sequencer_rise_detect.sv
// Rising-edge detector: one-cycle pulse when d goes 0 -> 1 between samples.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic d_q;

  // Remember the previous sample of d.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/game_sequencer.sv
// Game flow controller: menu -> countdown -> play -> game-over sequencing,
// motion gating and saturating speed level.
module game_sequencer
  import game_pkg::*;
#(
  parameter int unsigned COUNTDOWN_FRAMES = 60,
  parameter int unsigned GAMEOVER_FRAMES  = 120,
  parameter int unsigned LEVEL_STEP       = 10,
  parameter int unsigned MAX_LEVEL        = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               frame_tick,
  input  logic               dead,
  input  logic               score_tick,
  output logic               status,
  output logic               play_en,
  output logic [1:0]         countdown,
  output logic [LEVEL_W-1:0] speed_level,
  output logic               level_up,
  output logic               game_over
);

  localparam logic [CNT_W-1:0]   CD_LAST   = CNT_W'(COUNTDOWN_FRAMES - 1);
  localparam logic [CNT_W-1:0]   GO_LAST   = CNT_W'(GAMEOVER_FRAMES - 1);
  localparam logic [CNT_W-1:0]   STEP_LAST = CNT_W'(LEVEL_STEP - 1);
  localparam logic [LEVEL_W-1:0] LVL_MAX   = LEVEL_W'(MAX_LEVEL);

  state_t           state;
  logic [1:0]       digit;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] score_cnt;
  logic             start_rise;

  rise_detect u_start_rise (
    .clk   (clk),
    .rst_n (reset),
    .d     (start),
    .rise  (start_rise)
  );

  // Phase sequencing, frame/score counters and speed level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      digit       <= '0;
      frame_cnt   <= '0;
      score_cnt   <= '0;
      speed_level <= '0;
      level_up    <= 1'b0;
    end else begin
      level_up <= 1'b0;
      case (state)
        IDLE: begin
          if (start_rise) begin
            state       <= COUNT;
            digit       <= 2'd3;
            frame_cnt   <= '0;
            score_cnt   <= '0;
            speed_level <= '0;
          end
        end
        COUNT: begin
          if (frame_tick) begin
            if (frame_cnt == CD_LAST) begin
              frame_cnt <= '0;
              if (digit == 2'd1) begin
                state <= PLAY;
                digit <= '0;
              end else begin
                digit <= digit - 2'd1;
              end
            end else begin
              frame_cnt <= frame_cnt + CNT_W'(1);
            end
          end
        end
        PLAY: begin
          // Collision takes priority; a simultaneous score event is dropped.
          if (dead) begin
            state     <= OVER;
            frame_cnt <= '0;
          end else if (score_tick) begin
            if (score_cnt == STEP_LAST) begin
              score_cnt <= '0;
              if (speed_level != LVL_MAX) begin
                speed_level <= speed_level + LEVEL_W'(1);
                level_up    <= 1'b1;
              end
            end else begin
              score_cnt <= score_cnt + CNT_W'(1);
            end
          end
        end
        OVER: begin
          if (frame_tick) begin
            if (frame_cnt == GO_LAST) begin
              state     <= IDLE;
              frame_cnt <= '0;
            end else begin
              frame_cnt <= frame_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Moore decode of the registered phase.
  always_comb begin
    status    = (state == PLAY);
    play_en   = (state == PLAY);
    game_over = (state == OVER);
    countdown = (state == COUNT) ? digit : 2'd0;
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer with small frame/step parameters.
module tb_game_sequencer;

  typedef struct packed {
    logic       status;
    logic       play_en;
    logic [1:0] countdown;
    logic [2:0] speed_level;
    logic       level_up;
    logic       game_over;
  } out_t;

  logic       clk;
  logic       reset;
  logic       start;
  logic       frame_tick;
  logic       dead;
  logic       score_tick;
  logic       status;
  logic       play_en;
  logic [1:0] countdown;
  logic [2:0] speed_level;
  logic       level_up;
  logic       game_over;

  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;
  out_t exp_q[$];

  game_sequencer #(
    .COUNTDOWN_FRAMES (2),
    .GAMEOVER_FRAMES  (3),
    .LEVEL_STEP       (2),
    .MAX_LEVEL        (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .frame_tick  (frame_tick),
    .dead        (dead),
    .score_tick  (score_tick),
    .status      (status),
    .play_en     (play_en),
    .countdown   (countdown),
    .speed_level (speed_level),
    .level_up    (level_up),
    .game_over   (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic out_t sample();
    return '{status, play_en, countdown, speed_level, level_up, game_over};
  endfunction

  function automatic out_t mk(input logic s, input logic p, input logic [1:0] c,
                              input logic [2:0] l, input logic u, input logic g);
    return '{s, p, c, l, u, g};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    out_t e, o;
    reset = 1'b1; start = 1'b0; frame_tick = 1'b0; dead = 1'b0; score_tick = 1'b0;
    #2 reset = 1'b0;
    exp_q.push_back(mk(0, 0, 2'd0, 3'd0, 0, 0));
    step(); step();
    e = exp_q.pop_front(); o = sample(); tests_run++;
    if (o !== e) begin
      tests_failed++;
      $display("FAIL reset_state: got %b expected %b", o, e);
    end
    reset = 1'b1;
    exp_q.push_back(mk(0, 0, 2'd0, 3'd0, 0, 0));
    step();
    e = exp_q.pop_front(); o = sample(); tests_run++;
    if (o !== e) begin
      tests_failed++;
      $display("FAIL reset_release_idle: got %b expected %b", o, e);
    end
  endtask

  task automatic test_start_hold();
    out_t e, o;
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(mk(0, 0, 2'd3, 3'd0, 0, 0));
      step();
      e = exp_q.pop_front(); o = sample(); tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL start_hold cycle %0d: got %b expected %b", i, o, e);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_countdown();
    out_t e, o;
    logic [1:0] cd_tab [12] = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd2, 2'd2,
                                2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0};
    for (int i = 0; i < 12; i++) begin
      frame_tick = (i % 2 == 0);
      // Dead/score during countdown must have no effect.
      dead = (i == 3);
      score_tick = (i == 5);
      if (i >= 10) exp_q.push_back(mk(1, 1, 2'd0, 3'd0, 0, 0));
      else         exp_q.push_back(mk(0, 0, cd_tab[i], 3'd0, 0, 0));
      step();
      e = exp_q.pop_front(); o = sample(); tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL countdown step %0d: got %b expected %b", i, o, e);
      end
    end
    frame_tick = 1'b0; dead = 1'b0; score_tick = 1'b0;
  endtask

  task automatic test_score_levels();
    out_t e, o;
    int unsigned pulses = 0;
    logic [2:0] lv_tab [12] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1,
                                3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2};
    logic       lu_tab [12] = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    for (int i = 0; i < 12; i++) begin
      score_tick = (i % 2 == 0);
      exp_q.push_back(mk(1, 1, 2'd0, lv_tab[i], lu_tab[i], 0));
      step();
      if (level_up === 1'b1) pulses++;
      e = exp_q.pop_front(); o = sample(); tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL score_level step %0d: got %b expected %b", i, o, e);
      end
    end
    score_tick = 1'b0;
    tests_run++;
    if (pulses != 2) begin
      tests_failed++;
      $display("FAIL level_up_count: got %0d expected 2", pulses);
    end
  endtask

  task automatic test_dead_over();
    out_t e, o;
    logic st_tab [7] = '{0, 1, 0, 1, 0, 0, 0};
    logic tk_tab [7] = '{0, 0, 1, 1, 0, 1, 0};
    for (int i = 0; i < 7; i++) begin
      dead       = (i == 0);
      score_tick = (i == 0);
      start      = st_tab[i];
      frame_tick = tk_tab[i];
      if (i < 5) exp_q.push_back(mk(0, 0, 2'd0, 3'd2, 0, 1));
      else       exp_q.push_back(mk(0, 0, 2'd0, 3'd2, 0, 0));
      step();
      e = exp_q.pop_front(); o = sample(); tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL dead_over step %0d: got %b expected %b", i, o, e);
      end
    end
    dead = 1'b0; score_tick = 1'b0; start = 1'b0; frame_tick = 1'b0;
  endtask

  task automatic test_reset_mid_play();
    out_t e, o;
    logic [1:0] cd_tab [6] = '{2'd3, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0};
    logic [2:0] lv_tab [4] = '{3'd0, 3'd1, 3'd1, 3'd2};
    logic       lu_tab [4] = '{0, 1, 0, 1};
    start = 1'b1;
    exp_q.push_back(mk(0, 0, 2'd3, 3'd0, 0, 0));
    step();
    start = 1'b0;
    e = exp_q.pop_front(); o = sample(); tests_run++;
    if (o !== e) begin
      tests_failed++;
      $display("FAIL restart_level_clear: got %b expected %b", o, e);
    end
    for (int i = 0; i < 6; i++) begin
      frame_tick = 1'b1;
      if (i == 5) exp_q.push_back(mk(1, 1, 2'd0, 3'd0, 0, 0));
      else        exp_q.push_back(mk(0, 0, cd_tab[i], 3'd0, 0, 0));
      step();
      e = exp_q.pop_front(); o = sample(); tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL back_to_back_countdown step %0d: got %b expected %b", i, o, e);
      end
    end
    frame_tick = 1'b0;
    for (int i = 0; i < 4; i++) begin
      score_tick = 1'b1;
      exp_q.push_back(mk(1, 1, 2'd0, lv_tab[i], lu_tab[i], 0));
      step();
      e = exp_q.pop_front(); o = sample(); tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL back_to_back_score step %0d: got %b expected %b", i, o, e);
      end
    end
    score_tick = 1'b0;
    #1 reset = 1'b0;
    exp_q.push_back(mk(0, 0, 2'd0, 3'd0, 0, 0));
    #1;
    e = exp_q.pop_front(); o = sample(); tests_run++;
    if (o !== e) begin
      tests_failed++;
      $display("FAIL async_reset_mid_play: got %b expected %b", o, e);
    end
    step(); step();
    reset = 1'b1;
    exp_q.push_back(mk(0, 0, 2'd0, 3'd0, 0, 0));
    step();
    e = exp_q.pop_front(); o = sample(); tests_run++;
    if (o !== e) begin
      tests_failed++;
      $display("FAIL post_reset_idle: got %b expected %b", o, e);
    end
    start = 1'b1;
    exp_q.push_back(mk(0, 0, 2'd3, 3'd0, 0, 0));
    step();
    start = 1'b0;
    e = exp_q.pop_front(); o = sample(); tests_run++;
    if (o !== e) begin
      tests_failed++;
      $display("FAIL post_reset_start: got %b expected %b", o, e);
    end
  endtask

  initial begin
    test_reset();
    test_start_hold();
    test_countdown();
    test_score_levels();
    test_dead_over();
    test_reset_mid_play();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
